// File: rtl/set_pkg.sv
// set_pkg: shared state encoding, grid defaults, mode codes and field offsets for the circle-set scanner
package set_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam int GRID_DEF = 8;
  localparam int POS_W = 5;
  localparam logic [1:0] MODE_A = 2'b00, MODE_AND = 2'b01, MODE_XOR = 2'b10, MODE_TWO = 2'b11;
  localparam int XA_OFF = 20, YA_OFF = 16, XB_OFF = 12, YB_OFF = 8, XC_OFF = 4, YC_OFF = 0;
  localparam int RA_SQ_OFF = 16, RB_SQ_OFF = 8, RC_SQ_OFF = 0;
  function automatic logic [7:0] sq4(input logic [3:0] v);
    return {4'd0, v} * {4'd0, v};
  endfunction
endpackage

// File: rtl/grid_scan_cnt.sv
// grid_scan_cnt: raster x/y counter over 1..GRID with start, step and last-point flag
module grid_scan_cnt #(
  parameter int GRID = 8,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         last
);
  assign last = (x == W'(GRID)) && (y == W'(GRID));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= W'(1);
      y <= W'(1);
    end else if (step) begin
      x <= last ? '0 : (x == W'(GRID)) ? W'(1) : x + W'(1);
      y <= last ? '0 : (x == W'(GRID)) ? y + W'(1) : y;
    end
  end
endmodule

// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: latches a circle-set job, scans the grid through the evaluator and reports the activated count
module set_scan_ctrl
  import set_pkg::*;
#(
  parameter int GRID = GRID_DEF,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] central,
  input  logic [11:0] radius,
  input  logic [1:0]  mode,
  output logic [23:0] eval_central,
  output logic [23:0] eval_radius_square,
  output logic [1:0]  eval_mode,
  output logic [4:0]  position_x,
  output logic [4:0]  position_y,
  input  logic        activated,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  candidate
);
  state_t state, state_nx;
  logic start, step, last;
  logic [CNT_W-1:0] count, cand;
  grid_scan_cnt #(.GRID(GRID), .W(POS_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step),
    .x(position_x), .y(position_y), .last(last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    start = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        start = en;
        state_nx = en ? SCAN : IDLE;
      end
      SCAN: begin
        step = 1'b1;
        state_nx = last ? DONE : SCAN;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign valid = state == DONE;
  assign candidate = 8'(cand);
  // the final point's result is folded in as candidate loads, so it is visible alongside valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_central <= '0;
      eval_radius_square <= '0;
      eval_mode <= '0;
      count <= '0;
      cand <= '0;
    end else begin
      if (start) begin
        eval_central <= central;
        eval_mode <= mode;
        eval_radius_square[RA_SQ_OFF +: 8] <= sq4(radius[11:8]);
        eval_radius_square[RB_SQ_OFF +: 8] <= sq4(radius[7:4]);
        eval_radius_square[RC_SQ_OFF +: 8] <= sq4(radius[3:0]);
        count <= '0;
      end
      if (step) count <= count + CNT_W'(activated);
      if (step && last) cand <= count + CNT_W'(activated);
    end
  end
endmodule

// File: doc/set_scan_ctrl.md
Name: set_scan_ctrl

Overview:
Sequential front/back end for the circle-set inclusion evaluator. It accepts one job (three circle centres, three radii, a mode) and latches it. It then scans the GRID x GRID point grid one point per cycle, driving the evaluator's position inputs and consuming its combinational activated result. At the end it reports the count of activated points with a one-cycle valid pulse.

Parameters:
GRID, 8, grid edge length; coordinates scanned are 1..GRID on both axes
CNT_W, 7, candidate counter width; must hold GRID*GRID (64)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  job start strobe; sampled only in IDLE
central  in  24  {xA,yA,xB,yB,xC,yC}, 4 bits each, MSB first
radius  in  12  {rA,rB,rC}, 4 bits each, unsigned
mode  in  2  set-combination mode, passed through to evaluator
eval_central  out  24  latched central, to evaluator
eval_radius_square  out  24  {rA^2,rB^2,rC^2}, 8 bits each, latched
eval_mode  out  2  latched mode
position_x  out  5  current scan x, to evaluator
position_y  out  5  current scan y, to evaluator
activated  in  1  evaluator result for current position (combinational, same cycle)
busy  out  1  job in progress; high from cycle after accepted en through DONE
valid  out  1  one-cycle pulse, candidate is valid
candidate  out  8  activated-point count, zero-extended from CNT_W

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE
  - busy=0, valid=0, candidate=0
  - position_x=position_y=0
  - all eval_* registers=0
  - internal count=0
  - Reset mid-scan aborts the job entirely; no partial result is reported.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - busy=0, position=(0,0).
  - When en=1: latch central, mode, and squared radii. Each square is computed as a 4b x 4b -> 8b product, so 15 -> 225 with no overflow.
  - In the same edge, set position=(1,1), count=0, state=SCAN.
  - en=0 keeps the block in IDLE.
- SCAN, every cycle:
  - count += activated for the current position.
  - x advances 1..GRID; at x=GRID, x wraps to 1 and y increments.
  - When the counted point is (GRID,GRID), go to DONE and set position=(0,0).
  - SCAN always lasts exactly GRID*GRID cycles.
- DONE, one cycle:
  - candidate<=count (registered; visible in the same cycle as valid), valid=1, busy=1.
  - Next state is IDLE.
- Latency: en sampled at edge 0 -> SCAN occupies cycles 1..64 -> valid high in cycle 65 -> busy low in cycle 66. An en in cycle 66 starts the next job (back-to-back allowed).
- en while busy (SCAN or DONE) is ignored. Latched eval_* values stay unchanged for the whole job.
- candidate holds its value until the next job's DONE or reset. valid is never high for more than one cycle.
- count saturates at neither end; by construction it lies in 0..64.
- eval_* outputs hold the last job's values in IDLE.
- No combinational path from any input to any output, except none required. activated is consumed only via count.

Decomposition:
- Shared package (set_pkg):
  - state enum {IDLE, SCAN, DONE}
  - GRID default
  - mode codes: 00 A only, 01 A&B, 10 A xor B, 11 exactly two of three
  - field offsets of central and radius_square
- Sub-module grid_scan_cnt: x/y counter with start, step, and last-point flag, parameterised by GRID.
- Radius squaring and the FSM stay in set_scan_ctrl.

Test Plan:
1. Behavioural evaluator with strict d^2<r^2, mode=00, A=(4,4), rA=2, en for 1 cycle -> eval_radius_square[23:16]=4, valid in cycle 65, candidate=9, busy low in cycle 66.
2. activated tied 1 -> candidate=64 (full count, no wrap). activated tied 0 -> candidate=0, valid still exactly in cycle 65.
3. radius={15,15,15} -> eval_radius_square=24'hE1E1E1. Position trace visits (1,1),(2,1)..(8,1),(1,2)..(8,8) exactly once each in order.
4. en pulsed at scan cycles 10 and 65 with different central/mode -> ignored, eval_* unchanged, single valid pulse.
5. rst_n low at scan cycle 30 -> busy, valid, candidate, position immediately 0. The new job after release completes correctly with count from 0.
6. en held high continuously -> jobs start at cycles 0, 66, 132, ... with valid at 65, 131, ..., each candidate correct.
